chan_mux_scan: RTL and testbench
================================

# chan_mux_scan

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan channel selection. Generalises the 4:1 single-bit input mux into a configurable front-end selector feeding `uo_out` in a tile design. In scan mode it steps through channels on a programmable dwell interval and flags each wrap-around.

## Interface

Parameters:
- `NCH`, 4, number of input channels (2..16; need not be a power of two)
- `W`, 1, bits per channel
- `DWELL_W`, 8, width of the dwell-interval input
- `SEL_W`, derived as $clog2(NCH); not user-set

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  NCH*W  channel c occupies bits [c*W +: W]
- `mode`  in  1  0 = manual, 1 = scan
- `sel_in`  in  SEL_W  channel index for a manual load
- `sel_load`  in  1  single-cycle strobe; latches `sel_in`
- `dwell`  in  DWELL_W  each channel is held for dwell+1 cycles in scan mode
- `chan_en`  in  NCH  per-channel enable (present only with CHAN_MUX_MASK_EN)
- `out_data`  out  W  registered selected channel
- `out_valid`  out  1  high when `out_data` holds a valid sample
- `cur_sel`  out  SEL_W  registered current channel index
- `wrap`  out  1  one-cycle pulse when the scan steps from the last channel to the first

## Operation

- Reset values: `cur_sel` = 0, dwell count = 0, `out_data` = 0, `out_valid` = 0, `wrap` = 0.
- Every cycle out of reset, `out_data` <= `in_data[cur_sel]`, and `out_valid` <= 1.
- Manual mode:
  - `cur_sel` changes only on `sel_load`.
  - If `sel_in` >= NCH, the load is ignored and `cur_sel` keeps its value.
- Scan mode, dwell counter:
  - Increments every cycle.
  - When count >= `dwell`, the count clears and `cur_sel` advances to `cur_sel`+1.
  - At NCH-1 the step goes to 0 and `wrap` pulses on that same update edge.
- Scan mode, `dwell` input: it is compared live, so a change takes effect immediately. Lowering `dwell` below the current count forces an advance on the next edge.
- `sel_load` in scan mode:
  - A valid `sel_in` jumps `cur_sel` to it and clears the count. No `wrap` pulse.
  - The load has priority over a same-cycle advance.
- Mode changes:
  - Manual -> scan: starts counting from 0 at the current `cur_sel`.
  - Scan -> manual: freezes `cur_sel`; the count is cleared.
- Reset mid-scan returns all outputs to their reset values on the same edge.

## Timing

- Select-to-data latency: `out_data` reflects the new `cur_sel` one cycle after `cur_sel` updates.
  - So the sequence is: `sel_load` at edge k sets `cur_sel` at edge k, and the corresponding data appears at edge k+1.
- First valid output: `out_valid` rises on the first edge with `rst` low.
- Scan period: the full cycle through all channels is NCH*(dwell+1) cycles. `dwell` = 0 advances every cycle.
- `wrap` is high for exactly one cycle per full scan and is never asserted in manual mode.

## Configuration

- Macro: `CHAN_MUX_MASK_EN`.
- Defined:
  - The `chan_en` port exists.
  - Scan advances to the next enabled channel in circular order, skipping disabled ones in a single step.
  - `wrap` pulses whenever the step crosses from a higher index to a lower or equal one.
  - A manual load of a disabled channel is ignored.
  - If the current channel becomes disabled in scan mode, it is left at the next advance.
  - If all of `chan_en` is 0: `cur_sel` holds, the counter holds, `out_data` is driven to 0 and `out_valid` to 0.
- Undefined: the port is absent and all channels are treated as enabled.

## Structure

- Shared package `chan_mux_pkg`:
  - mode constants `MODE_MANUAL` = 0 and `MODE_SCAN` = 1
  - the default parameter values
  - a next-enabled-channel function, used under the macro
- Sub-module `chan_mux_dwell_timer`:
  - inputs: `clk`, `rst`, `enable`, `clear`, `dwell`
  - output: `tick` pulse
  - owns the dwell counter
- Top `chan_mux_scan` holds the select register, the output register and the wrap logic.

## Test plan

1. Reset, then manual mode (NCH=4, W=1), `in_data`=4'b0100, `sel_in`=2, `sel_load` pulse -> `cur_sel`=2 next edge, `out_data`=1 one edge later; `out_valid`=1 from first post-reset edge.
2. NCH=3, manual, `sel_in`=3 with `sel_load` -> `cur_sel` unchanged, no glitch on `out_data`.
3. Scan mode, `dwell`=2 -> `cur_sel` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; `wrap` high exactly on the 3->0 edge; period 12 cycles.
4. Scan mode, `sel_load` with `sel_in`=1 on the same cycle as a scheduled advance -> `cur_sel`=1, count restarts, next advance after dwell+1 cycles, no `wrap`.
5. Assert `rst` mid-scan at `cur_sel`=2 -> next edge: `cur_sel`=0, `out_data`=0, `out_valid`=0, `wrap`=0.
6. With CHAN_MUX_MASK_EN, `chan_en`=4'b1010, `dwell`=0 -> `cur_sel` 1,3,1,3 with `wrap` on each 3->1 step; then `chan_en`=0 -> `out_valid`=0, `out_data`=0, `cur_sel` held.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the chan_mux_scan channel selector.
// next_enabled() is only called when CHAN_MUX_MASK_EN is defined.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int NCH_DEFAULT     = 4;
  localparam int W_DEFAULT       = 1;
  localparam int DWELL_W_DEFAULT = 8;

  // Nearest enabled channel after cur in circular order; cur itself only if it is the sole one left.
  function automatic int next_enabled(input int cur, input logic [15:0] en, input int nch);
    int nxt;
    int idx;
    nxt = cur;
    for (int k = 16; k >= 1; k--) begin
      if (k <= nch) begin
        idx = (cur + k) % nch;
        if (en[4'(idx)]) nxt = idx;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/chan_mux_dwell_timer.sv
// Dwell counter for scan mode: tick fires on the cycle the count reaches the
// live dwell value, and the count restarts from zero on that same edge.
module chan_mux_dwell_timer
  import chan_mux_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] count;

  assign tick = enable && !clear && (count >= dwell);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/chan_mux_scan.sv
// N-channel registered multiplexer with manual and auto-scan selection.
// Optional macro CHAN_MUX_MASK_EN adds the chan_en per-channel enable port.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int NCH     = NCH_DEFAULT,
  parameter int W       = W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT,
  localparam int SEL_W  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*W-1:0]   in_data,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_load,
  input  logic [DWELL_W-1:0] dwell,
`ifdef CHAN_MUX_MASK_EN
  input  logic [NCH-1:0]     chan_en,
`endif
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap
);

  localparam logic [SEL_W:0]   NCH_V    = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

  logic [15:0]      en16;
  logic             any_en;
  logic             scan;
  logic             load_ok;
  logic             tick;
  logic [SEL_W-1:0] step_sel;
  logic             step_wrap;

  // Without the mask every channel counts as enabled.
  always_comb begin
    en16 = '0;
`ifdef CHAN_MUX_MASK_EN
    en16[NCH-1:0] = chan_en;
`else
    en16[NCH-1:0] = {NCH{1'b1}};
`endif
  end

  assign any_en  = |en16;
  assign scan    = (mode == MODE_SCAN);
  assign load_ok = sel_load && ({1'b0, sel_in} < NCH_V) && en16[4'(sel_in)];

  chan_mux_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (scan && any_en),
    .clear  (!scan || load_ok),
    .dwell  (dwell),
    .tick   (tick)
  );

  always_comb begin
`ifdef CHAN_MUX_MASK_EN
    step_sel  = SEL_W'(next_enabled(int'(cur_sel), en16, NCH));
    step_wrap = (step_sel <= cur_sel);
`else
    step_sel  = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
    step_wrap = (cur_sel == LAST_SEL);
`endif
  end

  // A valid load wins over a scan advance; tick is already masked by the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel   <= '0;
      wrap      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load_ok) begin
        cur_sel <= sel_in;
      end else if (tick) begin
        cur_sel <= step_sel;
        wrap    <= step_wrap;
      end
      if (any_en) begin
        out_data  <= in_data[int'(cur_sel)*W +: W];
        out_valid <= 1'b1;
      end else begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Scoreboard bench for chan_mux_scan: a channel-level reference model queues the
// expected post-edge outputs, and a separate monitor compares them every cycle.
module tb_chan_mux_scan;

  localparam int NCH     = 5;
  localparam int W       = 3;
  localparam int DWELL_W = 4;
  localparam int SEL_W   = $clog2(NCH);
  localparam int IN_W    = NCH * W;

  logic               clk = 1'b0;
  logic               rst;
  logic [IN_W-1:0]    in_data;
  logic               mode;
  logic [SEL_W-1:0]   sel_in;
  logic               sel_load;
  logic [DWELL_W-1:0] dwell;
  logic [NCH-1:0]     chan_en;
  logic [W-1:0]       out_data;
  logic               out_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;

  typedef struct {
    int sel;
    int data;
    int valid;
    int wrap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;
  int   m_sel  = 0;
  int   m_cnt  = 0;

  always #5 clk = ~clk;

  chan_mux_scan #(
    .NCH     (NCH),
    .W       (W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .mode      (mode),
    .sel_in    (sel_in),
    .sel_load  (sel_load),
    .dwell     (dwell),
`ifdef CHAN_MUX_MASK_EN
    .chan_en   (chan_en),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .wrap      (wrap)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour for one rising edge given the inputs now on the pins.
  task automatic modelStep();
    exp_t e;
    int   en;
    int   nxt;
    bit   load_ok;
    en = (1 << NCH) - 1;
`ifdef CHAN_MUX_MASK_EN
    en = int'(chan_en);
`endif
    e = '{0, 0, 0, 0};
    if (rst) begin
      m_sel = 0;
      m_cnt = 0;
    end else begin
      e.valid = (en != 0) ? 1 : 0;
      e.data  = (en != 0) ? ((int'(in_data) >> (m_sel * W)) & ((1 << W) - 1)) : 0;
      load_ok = sel_load && (int'(sel_in) < NCH) && en[int'(sel_in)];
      if (load_ok) begin
        m_sel = int'(sel_in);
        m_cnt = 0;
      end else if (mode == 1'b0) begin
        m_cnt = 0;
      end else if (en != 0) begin
        if (m_cnt >= int'(dwell)) begin
          nxt = m_sel;
          for (int k = 1; k <= NCH; k++) begin
            if (en[(m_sel + k) % NCH]) begin
              nxt = (m_sel + k) % NCH;
              break;
            end
          end
          e.wrap = (nxt <= m_sel) ? 1 : 0;
          m_sel  = nxt;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
      e.sel = m_sel;
    end
    q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic m, input int s, input logic l,
                               input int d, input int n);
    for (int i = 0; i < n; i++) begin
      rst      = r;
      mode     = m;
      sel_in   = SEL_W'(s);
      sel_load = l;
      dwell    = DWELL_W'(d);
      in_data  = IN_W'($urandom);
      modelStep();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    while (1) begin
      @(posedge clk);
      #1;
      if (done) break;
      cyc++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underrun at cycle %0d: got empty queue, expected an entry", cyc);
      end else begin
        e = q.pop_front();
        checkOutput("cur_sel",   int'(cur_sel),   e.sel);
        checkOutput("out_data",  int'(out_data),  e.data);
        checkOutput("out_valid", int'(out_valid), e.valid);
        checkOutput("wrap",      int'(wrap),      e.wrap);
      end
    end
  end

  initial begin
    logic r_mode;
    int   r_dwell;
    rst      = 1'b1;
    mode     = 1'b0;
    sel_in   = '0;
    sel_load = 1'b0;
    dwell    = '0;
    in_data  = '0;
    chan_en  = '1;

    applyStimulus(1, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 2, 1, 0, 1);
    applyStimulus(0, 0, 2, 0, 0, 3);
    applyStimulus(0, 0, 6, 1, 0, 1);
    applyStimulus(0, 0, 5, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 2, 40);
    applyStimulus(0, 1, 1, 1, 2, 1);
    applyStimulus(0, 1, 0, 0, 2, 8);
    applyStimulus(0, 1, 0, 0, 1, 5);
    applyStimulus(1, 1, 0, 0, 1, 2);
    applyStimulus(0, 1, 0, 0, 0, 12);
    applyStimulus(0, 1, 0, 0, 5, 4);
    applyStimulus(0, 1, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 1, 3);
    applyStimulus(0, 1, 0, 0, 1, 6);
`ifdef CHAN_MUX_MASK_EN
    chan_en = 5'b01010;
    applyStimulus(0, 1, 0, 0, 0, 10);
    applyStimulus(0, 0, 2, 1, 0, 2);
    chan_en = '0;
    applyStimulus(0, 1, 0, 0, 0, 4);
    chan_en = '1;
`endif

    r_mode  = 1'b1;
    r_dwell = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 9) == 0) r_dwell = $urandom_range(0, 5);
`ifdef CHAN_MUX_MASK_EN
      if ($urandom_range(0, 19) == 0)
        chan_en = ($urandom_range(0, 7) == 0) ? '0 : NCH'($urandom);
`endif
      applyStimulus(($urandom_range(0, 49) == 0), r_mode, $urandom_range(0, 7),
                    ($urandom_range(0, 6) == 0), r_dwell, 1);
    end

    done = 1'b1;
    #20;
    checkOutput("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
